// File: rtl/mouse_joy_emu.sv
// Mouse-to-analog-joystick emulator.
// PS/2 mouse deltas are scaled, clamped and accumulated into signed axis
// registers. These registers replace the analog joystick while the mouse is
// in use, and they hand control back to the joystick whenever the digital
// joystick moves or emulation is disabled. An optional slow decay pulls the
// axes back toward centre.
module mouse_joy_emu #(
  parameter int AXIS_W    = 8,
  parameter int DELTA_MAX = 10,
  parameter int SHIFT     = 1,
  parameter int DECAY_DIV = 4096
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [24:0]       ps2_mouse,
  input  logic [AXIS_W-1:0] joy_x,
  input  logic [AXIS_W-1:0] joy_y,
  input  logic              joy_fire,
  input  logic              joy_active,
  input  logic              enable,
  input  logic              mode,
  input  logic              invert_y,
  output logic [AXIS_W-1:0] out_x,
  output logic [AXIS_W-1:0] out_y,
  output logic [AXIS_W+3:0] adc_x,
  output logic [AXIS_W+3:0] adc_y,
  output logic              out_fire,
  output logic              emu_active
);

  // Working width: room for one clamped delta on top of a full-scale axis.
  localparam int SW = AXIS_W + 2;
  localparam int PW = (DECAY_DIV > 2) ? $clog2(DECAY_DIV) : 1;

  localparam logic signed [SW-1:0] D_MAX   = SW'(DELTA_MAX);
  localparam logic signed [SW-1:0] D_MIN   = -D_MAX;
  localparam logic signed [SW-1:0] SAT_MAX = SW'((2 ** (AXIS_W - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic [PW-1:0]        PS_LAST = PW'(DECAY_DIV - 1);

  logic                     old_stb;
  logic [PW-1:0]            prescaler;
  logic                     tick;
  logic                     mouse_evt;
  logic                     revert;
  logic signed [AXIS_W-1:0] acc_x;
  logic signed [AXIS_W-1:0] acc_y;
  logic signed [SW-1:0]     dx_c;
  logic signed [SW-1:0]     dy_c;
  logic signed [SW-1:0]     sum_x;
  logic signed [SW-1:0]     sum_y;
  logic signed [AXIS_W-1:0] nxt_x;
  logic signed [AXIS_W-1:0] nxt_y;

  // Packet bits that never influence the axes or fire.
  logic unused_bits;
  assign unused_bits = &{1'b0, ps2_mouse[7:6], ps2_mouse[3:2]};

  // The 9-bit two's-complement delta is widened, scaled down and then limited
  // so that a single fast swipe cannot slam the axis to full scale.
  function automatic logic signed [SW-1:0] scale_delta(input logic sgn,
                                                       input logic [7:0] mag);
    logic signed [8:0]    raw;
    logic signed [SW-1:0] shf;
    raw = {sgn, mag};
    shf = SW'(raw) >>> SHIFT;
    if (shf > D_MAX)      return D_MAX;
    else if (shf < D_MIN) return D_MIN;
    else                  return shf;
  endfunction

  function automatic logic signed [AXIS_W-1:0] saturate(input logic signed [SW-1:0] s);
    if (s > SAT_MAX)      return SAT_MAX[AXIS_W-1:0];
    else if (s < SAT_MIN) return SAT_MIN[AXIS_W-1:0];
    else                  return s[AXIS_W-1:0];
  endfunction

  function automatic logic signed [AXIS_W-1:0] toward_zero(input logic signed [AXIS_W-1:0] a);
    if (a > 0)      return a - AXIS_W'(1);
    else if (a < 0) return a + AXIS_W'(1);
    else            return a;
  endfunction

  assign mouse_evt = ps2_mouse[24] != old_stb;
  assign revert    = joy_active | ~enable;
  assign tick      = prescaler == PS_LAST;

  // Candidate accumulator values for a mouse event.
  always_comb begin
    dx_c  = scale_delta(ps2_mouse[4], ps2_mouse[15:8]);
    dy_c  = scale_delta(ps2_mouse[5], ps2_mouse[23:16]);
    sum_x = SW'(acc_x) + dx_c;
    sum_y = invert_y ? (SW'(acc_y) + dy_c) : (SW'(acc_y) - dy_c);
    nxt_x = saturate(sum_x);
    nxt_y = saturate(sum_y);
  end

  // The strobe tracker keeps following bit 24 through reset, so a toggle that
  // is already present when reset is released is not treated as new.
  always_ff @(posedge clk_sys) begin
    old_stb <= ps2_mouse[24];
  end

  // Free-running decay prescaler.
  always_ff @(posedge clk_sys) begin
    if (reset || tick) prescaler <= '0;
    else               prescaler <= prescaler + PW'(1);
  end

  // Accumulators. Revert beats an event, and an event beats the decay step.
  always_ff @(posedge clk_sys) begin
    if (reset || revert) begin
      acc_x      <= '0;
      acc_y      <= '0;
      emu_active <= 1'b0;
    end else if (mouse_evt) begin
      acc_x      <= nxt_x;
      acc_y      <= nxt_y;
      emu_active <= 1'b1;
    end else if (tick && mode) begin
      acc_x <= toward_zero(acc_x);
      acc_y <= toward_zero(acc_y);
    end
  end

  // Output source select and the offset-binary view for the ADC path.
  always_comb begin
    out_x    = emu_active ? acc_x : joy_x;
    out_y    = emu_active ? acc_y : joy_y;
    out_fire = emu_active ? (ps2_mouse[0] | ps2_mouse[1]) : joy_fire;
    adc_x    = {~out_x[AXIS_W-1], out_x[AXIS_W-2:0], 4'b0000};
    adc_y    = {~out_y[AXIS_W-1], out_y[AXIS_W-2:0], 4'b0000};
  end

endmodule

// File: tb/tb_mouse_joy_emu.sv
// Directed bench for mouse_joy_emu with a fast decay prescaler (DECAY_DIV=4).
module tb_mouse_joy_emu;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [24:0] ps2_mouse;
  logic [7:0]  joy_x, joy_y;
  logic        joy_fire, joy_active, enable, mode, invert_y;
  logic [7:0]  out_x, out_y;
  logic [11:0] adc_x, adc_y;
  logic        out_fire, emu_active;

  int total = 0;
  int bad   = 0;

  always #5 clk_sys = ~clk_sys;

  mouse_joy_emu #(
    .AXIS_W(8), .DELTA_MAX(10), .SHIFT(1), .DECAY_DIV(4)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ps2_mouse(ps2_mouse),
    .joy_x(joy_x), .joy_y(joy_y), .joy_fire(joy_fire),
    .joy_active(joy_active), .enable(enable), .mode(mode),
    .invert_y(invert_y), .out_x(out_x), .out_y(out_y),
    .adc_x(adc_x), .adc_y(adc_y), .out_fire(out_fire),
    .emu_active(emu_active)
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic send(input logic sx, input logic [7:0] dx,
                      input logic sy, input logic [7:0] dy);
    ps2_mouse[23:16] = dy;
    ps2_mouse[15:8]  = dx;
    ps2_mouse[5]     = sy;
    ps2_mouse[4]     = sx;
    ps2_mouse[24]    = ~ps2_mouse[24];
    step(1);
  endtask

  task automatic revert_once();
    enable = 1'b0;
    step(1);
    enable = 1'b1;
  endtask

  initial begin
    reset = 1'b1; ps2_mouse = '0;
    joy_x = 8'h55; joy_y = 8'h22; joy_fire = 1'b1;
    joy_active = 1'b0; enable = 1'b1; mode = 1'b0; invert_y = 1'b0;
    step(3);
    check("rst_out_x", out_x, 'h55);
    check("rst_out_y", out_y, 'h22);
    check("rst_emu", emu_active, 0);
    check("rst_fire", out_fire, 1);
    reset = 1'b0; joy_fire = 1'b0;
    step(2);
    check("idle_emu", emu_active, 0);

    // +40 -> 20 -> clamp 10
    send(1'b0, 8'h28, 1'b0, 8'h00);
    check("p10_x", $signed(out_x), 10);
    check("p10_emu", emu_active, 1);
    check("p10_adc_x", adc_x, 'h8A0);
    check("p10_y", $signed(out_y), 0);
    check("p10_adc_y", adc_y, 'h800);
    step(3);
    check("p10_hold", $signed(out_x), 10);

    // -80 -> -40 -> clamp -10
    revert_once();
    send(1'b1, 8'hB0, 1'b0, 8'h00);
    check("n10_x", $signed(out_x), -10);
    check("n10_adc_x", adc_x, 'h760);
    repeat (13) send(1'b0, 8'h28, 1'b0, 8'h00);
    check("sum120", $signed(out_x), 120);
    send(1'b0, 8'h28, 1'b0, 8'h00);
    check("sat_pos", $signed(out_x), 127);
    send(1'b0, 8'h28, 1'b0, 8'h00);
    check("sat_pos_hold", $signed(out_x), 127);
    check("sat_pos_adc", adc_x, 'hFF0);

    revert_once();
    repeat (13) send(1'b1, 8'hB0, 1'b0, 8'h00);
    check("sat_neg", $signed(out_x), -128);
    check("sat_neg_adc", adc_x, 'h000);

    // -3 >>> 1 = -2 (floor), 19 >>> 1 = 9 (no clamp)
    revert_once();
    send(1'b1, 8'hFD, 1'b0, 8'h00);
    check("shift_neg", $signed(out_x), -2);
    send(1'b0, 8'h13, 1'b0, 8'h00);
    check("shift_pos", $signed(out_x), 7);

    // Y direction
    revert_once();
    send(1'b0, 8'h00, 1'b0, 8'h06);
    check("dy_noinv", $signed(out_y), -3);
    check("dy_noinv_adc", adc_y, 'h7D0);
    revert_once();
    invert_y = 1'b1;
    send(1'b0, 8'h00, 1'b0, 8'h06);
    check("dy_inv", $signed(out_y), 3);
    invert_y = 1'b0;

    // Hold in mode 0, then decay in mode 1
    revert_once();
    send(1'b0, 8'h28, 1'b0, 8'h06);
    step(20);
    check("mode0_hold_x", $signed(out_x), 10);
    check("mode0_hold_y", $signed(out_y), -3);
    mode = 1'b1;
    step(8);
    check("decay8_x", $signed(out_x), 8);
    check("decay8_y", $signed(out_y), -1);
    step(12);
    check("decay20_x", $signed(out_x), 5);
    check("decay20_y", $signed(out_y), 0);
    step(20);
    check("decay40_x", $signed(out_x), 0);
    step(8);
    check("decay_stay0", $signed(out_x), 0);
    check("decay_emu", emu_active, 1);
    mode = 1'b0;

    // Event and joystick activity on the same edge
    send(1'b0, 8'h28, 1'b0, 8'h00);
    check("pre_joy_x", $signed(out_x), 10);
    joy_active = 1'b1;
    send(1'b0, 8'h28, 1'b0, 8'h00);
    check("joy_pri_emu", emu_active, 0);
    check("joy_pri_x", out_x, 'h55);
    joy_active = 1'b0;
    step(2);
    check("joy_after_x", out_x, 'h55);
    send(1'b0, 8'h00, 1'b0, 8'h00);
    check("acc_cleared", $signed(out_x), 0);
    check("reacquire_emu", emu_active, 1);

    // Buttons are level-sampled
    ps2_mouse[2:0] = 3'b001; step(1);
    check("btn_left", out_fire, 1);
    ps2_mouse[2:0] = 3'b010; step(1);
    check("btn_right", out_fire, 1);
    ps2_mouse[2:0] = 3'b100; step(1);
    check("btn_mid", out_fire, 0);
    ps2_mouse[2:0] = 3'b001;
    joy_fire = 1'b0;
    enable = 1'b0; step(1);
    check("dis_fire0", out_fire, 0);
    joy_fire = 1'b1; step(1);
    check("dis_fire1", out_fire, 1);
    check("dis_x", out_x, 'h55);
    enable = 1'b1; joy_fire = 1'b0; ps2_mouse[2:0] = 3'b000;

    // Reset mid-accumulation with a toggle arriving during reset
    send(1'b0, 8'h28, 1'b0, 8'h00);
    check("pre_rst_x", $signed(out_x), 10);
    reset = 1'b1; step(1);
    ps2_mouse[24] = ~ps2_mouse[24]; step(1);
    reset = 1'b0; step(3);
    check("post_rst_emu", emu_active, 0);
    check("post_rst_x", out_x, 'h55);
    send(1'b0, 8'h06, 1'b0, 8'h00);
    check("post_rst_evt", $signed(out_x), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
